// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch front end: bus width, reset PC,
// the NOP fill instruction and the fetch FSM encodings.
package inst_fetch_queue_pkg;

  localparam int DataSize = 32;

  localparam logic [DataSize-1:0] NOP_INST_DEF = 32'h00000013;
  localparam logic [DataSize-1:0] RESET_PC_DEF = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_queue_chk.sv
// Protocol checker for the instruction-memory port: a response may only arrive
// while a granted request is still unanswered.
module inst_fetch_queue_chk (
  input logic clk,
  input logic reset,
  input logic memReq,
  input logic memGnt,
  input logic memValid
);

  logic pend_q;

  // Track whether one granted request is waiting for its response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else if (memValid) begin
      pend_q <= 1'b0;
    end else if (memReq && memGnt) begin
      pend_q <= 1'b1;
    end else begin
      pend_q <= pend_q;
    end
  end

  a_no_stray_response: assert property (@(posedge clk) disable iff (reset) memValid |-> pend_q);

endmodule

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Show-ahead circular FIFO holding {pc, inst} pairs; head is visible
// combinationally and clear takes priority over push and pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign push_ok_s = push_i && (count_q != CW'(DEPTH)) && !clear_i;
  assign pop_ok_s  = pop_i && (count_q != {CW{1'b0}}) && !clear_i;

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: issues one outstanding instruction-memory request at a time,
// buffers responses in a show-ahead queue for IF_ID and handles branch redirects.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                DATA_W   = DataSize,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [DATA_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [DATA_W-1:0] flushAddr,
  input  logic              locker,
  output logic              memReq,
  output logic [DATA_W-1:0] memAddr,
  input  logic              memGnt,
  input  logic              memValid,
  input  logic [DATA_W-1:0] memData,
  output logic              instValid,
  output logic [DATA_W-1:0] instOut,
  output logic [DATA_W-1:0] pcOut
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] req_pc_q, req_pc_d;
  logic [CW-1:0]     count_s;
  logic [CW:0]       occupancy_s;
  logic [2*DATA_W-1:0] head_s;
  logic              room_s, req_s, push_s, pop_s, valid_s;

  // A request reserves a slot, so the in-flight response always fits.
  assign occupancy_s = {1'b0, count_s} + {{CW{1'b0}}, (state_q == WAIT)};
  assign room_s      = occupancy_s < (CW+1)'(DEPTH);
  assign valid_s     = (count_s != {CW{1'b0}});
  assign pop_s       = valid_s && !locker && !flush;

  // Fetch FSM next-state, request and push decode.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    req_s      = 1'b0;
    push_s     = 1'b0;
    case (state_q)
      IDLE: begin
        req_s = room_s && !flush && !reset;
        if (flush) begin
          fetch_pc_d = flushAddr;
        end else if (req_s && memGnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + DATA_W'(32'd4);
          state_d    = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (flush) begin
          fetch_pc_d = flushAddr;
          state_d    = memValid ? IDLE : DROP;
        end else if (memValid) begin
          push_s  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      DROP: begin
        if (flush) begin
          fetch_pc_d = flushAddr;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (memValid) begin
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and fetch address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*DATA_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (flush),
    .push_i      (push_s),
    .push_data_i ({req_pc_q, memData}),
    .pop_i       (pop_s),
    .count_o     (count_s),
    .head_o      (head_s)
  );

  assign memReq    = req_s;
  assign memAddr   = fetch_pc_q;
  assign instValid = valid_s;
  assign instOut   = valid_s ? head_s[DATA_W-1:0] : NOP_INST;
  assign pcOut     = valid_s ? head_s[2*DATA_W-1:DATA_W] : {DATA_W{1'b0}};

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: stimulus pushes expected requests, pops and
// output snapshots into queues; a negedge monitor pops and compares them.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flushAddr = 32'd0;
  logic        locker = 1'b0;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memGnt = 1'b0;
  logic        memValid = 1'b0;
  logic [31:0] memData = 32'd0;
  logic        instValid;
  logic [31:0] instOut;
  logic [31:0] pcOut;

  localparam bit [5:0] M_REQ = 6'd1, M_ADDR = 6'd2, M_VAL = 6'd4, M_PC = 6'd8,
                       M_INST = 6'd16, M_DRAIN = 6'd32;

  typedef struct {
    string       nm;
    bit [5:0]    m;
    logic        mreq;
    logic [31:0] maddr;
    logic        ival;
    logic [31:0] pc;
    logic [31:0] inst;
  } snap_t;

  snap_t       snap_q[$];
  logic [31:0] req_exp[$];
  logic [63:0] pop_exp[$];
  int          nvec = 0;
  int          nmis = 0;
  logic        auto_rsp = 1'b0;
  logic        grant_prev = 1'b0;
  logic [31:0] rsp_data = 32'd0;

  inst_fetch_queue dut (
    .clk(clk), .reset(reset), .flush(flush), .flushAddr(flushAddr), .locker(locker),
    .memReq(memReq), .memAddr(memAddr), .memGnt(memGnt), .memValid(memValid),
    .memData(memData), .instValid(instValid), .instOut(instOut), .pcOut(pcOut)
  );

  inst_fetch_queue_chk u_chk (
    .clk(clk), .reset(reset), .memReq(memReq), .memGnt(memGnt), .memValid(memValid)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask

  // Monitor: consume request/pop expectations and output snapshots mid-cycle.
  always @(negedge clk) begin
    snap_t       s;
    logic [31:0] a;
    logic [63:0] e;
    if (!reset) begin
      if (memReq && memGnt) begin
        if (req_exp.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL unexpected_req: got memAddr %h, expected no request", memAddr);
        end else begin
          a = req_exp.pop_front();
          cmp("req_addr", memAddr, a);
        end
      end
      if (instValid && !locker && !flush) begin
        if (pop_exp.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL unexpected_pop: got pc %h inst %h, expected no pop", pcOut, instOut);
        end else begin
          e = pop_exp.pop_front();
          cmp("pop_pc", pcOut, e[63:32]);
          cmp("pop_inst", instOut, e[31:0]);
        end
      end
    end
    while (snap_q.size() != 0) begin
      s = snap_q.pop_front();
      if (s.m[0]) cmp({s.nm, ".memReq"}, {31'd0, memReq}, {31'd0, s.mreq});
      if (s.m[1]) cmp({s.nm, ".memAddr"}, memAddr, s.maddr);
      if (s.m[2]) cmp({s.nm, ".instValid"}, {31'd0, instValid}, {31'd0, s.ival});
      if (s.m[3]) cmp({s.nm, ".pcOut"}, pcOut, s.pc);
      if (s.m[4]) cmp({s.nm, ".instOut"}, instOut, s.inst);
      if (s.m[5]) begin
        cmp({s.nm, ".req_left"}, 32'(req_exp.size()), 32'd0);
        cmp({s.nm, ".pop_left"}, 32'(pop_exp.size()), 32'd0);
      end
    end
  end

  task automatic expect_out(input string nm, input bit [5:0] m, input logic mreq,
                            input logic [31:0] maddr, input logic ival,
                            input logic [31:0] pc, input logic [31:0] inst);
    snap_t s;
    s.nm = nm; s.m = m; s.mreq = mreq; s.maddr = maddr;
    s.ival = ival; s.pc = pc; s.inst = inst;
    snap_q.push_back(s);
  endtask

  // One clock; the optional responder answers a grant seen this cycle in the next one.
  task automatic tick();
    @(negedge clk);
    grant_prev = memReq && memGnt;
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      memValid = grant_prev;
      memData  = rsp_data;
    end
  endtask

  task automatic do_reset(input logic gnt);
    reset = 1'b1; memValid = 1'b0; flush = 1'b0; locker = 1'b0;
    memGnt = gnt; memData = 32'd0;
    req_exp.delete(); pop_exp.delete();
    tick();
    expect_out("reset", M_REQ | M_ADDR | M_VAL | M_PC | M_INST,
               1'b0, 32'h0, 1'b0, 32'h0, 32'h00000013);
    tick();
    reset = 1'b0;
  endtask

  task automatic fill_four(input logic [31:0] d, input bit with_pops);
    for (int i = 0; i < 4; i++) begin
      req_exp.push_back(32'(i * 4));
      if (with_pops) pop_exp.push_back({32'(i * 4), d});
    end
  endtask

  initial begin
    // Free-running fetch with immediate grant and one-cycle responses.
    do_reset(1'b1); auto_rsp = 1'b1; rsp_data = 32'h00A00093;
    for (int i = 0; i < 6; i++) begin
      req_exp.push_back(32'(i * 4));
      pop_exp.push_back({32'(i * 4), rsp_data});
    end
    expect_out("t1_c0", M_REQ | M_ADDR | M_VAL, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    expect_out("t1_c1", M_REQ | M_VAL, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    expect_out("t1_c2", M_REQ | M_ADDR | M_VAL | M_PC | M_INST,
               1'b1, 32'h4, 1'b1, 32'h0, 32'h00A00093);
    repeat (10) tick();
    memGnt = 1'b0;
    tick();
    expect_out("t1_end", M_VAL | M_DRAIN, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Stall IF_ID until the queue fills, then drain on consecutive cycles.
    do_reset(1'b1); auto_rsp = 1'b1; rsp_data = 32'h00200113;
    fill_four(rsp_data, 1'b1);
    tick(); tick();
    locker = 1'b1;
    expect_out("t2_c2", M_VAL | M_PC, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);
    repeat (6) tick();
    expect_out("t2_full", M_REQ | M_VAL | M_PC | M_INST, 1'b0, 32'h0, 1'b1, 32'h0, 32'h00200113);
    tick(); tick();
    expect_out("t2_hold", M_REQ | M_VAL | M_PC, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);
    memGnt = 1'b0; locker = 1'b0;
    repeat (4) tick();
    expect_out("t2_end", M_VAL | M_DRAIN, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Flush in WAIT; the late response is dropped and fetch restarts at 0x40.
    do_reset(1'b1); auto_rsp = 1'b0;
    req_exp.push_back(32'h0);
    tick();
    flush = 1'b1; flushAddr = 32'h40;
    expect_out("t3_flush", M_REQ, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    flush = 1'b0;
    expect_out("t3_drop", M_REQ | M_VAL, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    memValid = 1'b1; memData = 32'hDEADBEEF;
    expect_out("t3_stale", M_REQ | M_VAL, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    memValid = 1'b0; req_exp.push_back(32'h40);
    expect_out("t3_restart", M_REQ | M_ADDR | M_VAL, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0);
    tick();
    memValid = 1'b1; memData = 32'h00000513; pop_exp.push_back({32'h40, 32'h00000513});
    tick();
    memValid = 1'b0; memGnt = 1'b0;
    expect_out("t3_head", M_VAL | M_PC | M_INST, 1'b0, 32'h0, 1'b1, 32'h40, 32'h00000513);
    tick();
    expect_out("t3_end", M_VAL | M_DRAIN, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Flush and response together in WAIT: response discarded.
    do_reset(1'b1); auto_rsp = 1'b0;
    req_exp.push_back(32'h0);
    tick();
    flush = 1'b1; flushAddr = 32'h80; memValid = 1'b1; memData = 32'h11111111;
    tick();
    flush = 1'b0; memValid = 1'b0; req_exp.push_back(32'h80);
    expect_out("t4_after", M_REQ | M_ADDR | M_VAL, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0);
    tick();
    memValid = 1'b1; memData = 32'h22222222; pop_exp.push_back({32'h80, 32'h22222222});
    tick();
    memValid = 1'b0; memGnt = 1'b0;
    expect_out("t4_head", M_VAL | M_PC | M_INST, 1'b0, 32'h0, 1'b1, 32'h80, 32'h22222222);
    tick();
    expect_out("t4_end", M_VAL | M_DRAIN, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Full queue: flush wins over a pop in the same cycle.
    do_reset(1'b1); auto_rsp = 1'b1; rsp_data = 32'h00300193;
    fill_four(rsp_data, 1'b0);
    tick(); tick();
    locker = 1'b1;
    repeat (6) tick();
    expect_out("t5_full", M_REQ | M_VAL | M_PC, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);
    flush = 1'b1; flushAddr = 32'h100; locker = 1'b0;
    tick();
    flush = 1'b0; memGnt = 1'b0;
    expect_out("t5_after", M_REQ | M_ADDR | M_VAL, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
    tick();
    expect_out("t5_end", M_VAL | M_DRAIN, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Three queued plus response arriving with flush and pop in one cycle.
    do_reset(1'b1); auto_rsp = 1'b1; rsp_data = 32'h00400213;
    fill_four(rsp_data, 1'b0);
    tick(); tick();
    locker = 1'b1;
    repeat (5) tick();
    expect_out("t5b_wait", M_REQ | M_VAL | M_PC, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);
    flush = 1'b1; flushAddr = 32'h200; locker = 1'b0;
    tick();
    flush = 1'b0;
    req_exp.push_back(32'h200); pop_exp.push_back({32'h200, rsp_data});
    expect_out("t5b_after", M_REQ | M_ADDR | M_VAL, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
    tick(); tick();
    memGnt = 1'b0;
    expect_out("t5b_head", M_VAL | M_PC | M_INST, 1'b0, 32'h0, 1'b1, 32'h200, 32'h00400213);
    tick();
    expect_out("t5b_end", M_VAL | M_DRAIN, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Grant withheld: request and address stay put, no advance.
    do_reset(1'b0); auto_rsp = 1'b1; rsp_data = 32'h00500293;
    for (int i = 0; i < 5; i++) begin
      expect_out("t6_nognt", M_REQ | M_ADDR | M_VAL, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      tick();
    end
    memGnt = 1'b1; req_exp.push_back(32'h0); pop_exp.push_back({32'h0, rsp_data});
    tick();
    expect_out("t6_wait", M_REQ | M_VAL, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    memGnt = 1'b0;
    expect_out("t6_next", M_REQ | M_ADDR | M_VAL | M_PC | M_INST,
               1'b1, 32'h4, 1'b1, 32'h0, 32'h00500293);
    tick();
    expect_out("t6_end", M_VAL | M_DRAIN, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
